// File: rtl/reveal_ctrl_if.sv
// Request/response handshake between the game logic and reveal_ctrl.
// The master issues reveal requests; the slave reports progress and completion.
interface reveal_ctrl_if;
  logic       click_req;
  logic [2:0] click_row;
  logic [2:0] click_col;
  logic       busy;
  logic       done;

  modport master (
    output click_req, click_row, click_col,
    input  busy, done
  );

  modport slave (
    input  click_req, click_row, click_col,
    output busy, done
  );
endinterface

// File: rtl/reveal_ctrl.sv
// Minesweeper cell reveal controller: reveals a clicked cell and flood-fills
// zero-valued regions one neighbour per cycle using a pending-cell mask.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request; reveals the clicked cell on accept
// SCAN   | pick lowest pending zero cell as centre, or finish
// EXPAND | visit the 8 neighbours of the centre, one per cycle
// DONE   | one-cycle completion pulse
module reveal_ctrl (
  input  logic                clk,
  input  logic                rst,
  input  logic [255:0]        map_flat,
  input  logic                clear,
  input  logic                game_over,
  reveal_ctrl_if.slave        rif,
  output logic [63:0]         clicked_flat,
  output logic [5:0]          num_clicked
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_EXPAND = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]  state_q,   state_d;
  logic [63:0] clicked_q, clicked_d;
  logic [63:0] pending_q, pending_d;
  logic [5:0]  num_q,     num_d;
  logic [5:0]  centre_q,  centre_d;
  logic [2:0]  nbr_q,     nbr_d;

  logic [5:0]  click_idx;
  logic [5:0]  low_idx;
  logic [3:0]  d_row, d_col;
  logic [3:0]  n_row, n_col;
  logic        nbr_ok;
  logic [5:0]  nbr_idx;
  logic [5:0]  num_inc;

  function automatic logic [3:0] cell_val(input logic [255:0] m, input logic [5:0] idx);
    return m[{idx, 2'b00} +: 4];
  endfunction

  assign click_idx = {rif.click_row, rif.click_col};
  assign num_inc   = (num_q == 6'd63) ? num_q : num_q + 6'd1;

  always_comb begin
    low_idx = 6'd0;
    for (int i = 63; i >= 0; i--) begin
      if (pending_q[i]) low_idx = i[5:0];
    end
  end

  // Neighbour order (drow,dcol): row -1 sweep, then row 0 sides, then row +1 sweep.
  always_comb begin
    d_row = 4'h0;
    d_col = 4'h0;
    case (nbr_q)
      3'd0: begin d_row = 4'hF; d_col = 4'hF; end
      3'd1: begin d_row = 4'hF; d_col = 4'h0; end
      3'd2: begin d_row = 4'hF; d_col = 4'h1; end
      3'd3: begin d_row = 4'h0; d_col = 4'hF; end
      3'd4: begin d_row = 4'h0; d_col = 4'h1; end
      3'd5: begin d_row = 4'h1; d_col = 4'hF; end
      3'd6: begin d_row = 4'h1; d_col = 4'h0; end
      default: begin d_row = 4'h1; d_col = 4'h1; end
    endcase
  end

  // Both -1 (4'hF) and 8 (4'h8) have bit 3 set, so bit 3 flags out-of-bounds.
  assign n_row   = {1'b0, centre_q[5:3]} + d_row;
  assign n_col   = {1'b0, centre_q[2:0]} + d_col;
  assign nbr_ok  = ~n_row[3] & ~n_col[3];
  assign nbr_idx = {n_row[2:0], n_col[2:0]};

  always_comb begin
    state_d   = state_q;
    clicked_d = clicked_q;
    pending_d = pending_q;
    num_d     = num_q;
    centre_d  = centre_q;
    nbr_d     = nbr_q;

    case (state_q)
      S_IDLE: begin
        if (rif.click_req && !game_over && !clear) begin
          state_d = S_DONE;
          if (!clicked_q[click_idx]) begin
            clicked_d[click_idx] = 1'b1;
            num_d                = num_inc;
            if (cell_val(map_flat, click_idx) == 4'd0) begin
              pending_d[click_idx] = 1'b1;
              state_d              = S_SCAN;
            end
          end
        end
      end
      S_SCAN: begin
        if (|pending_q) begin
          pending_d[low_idx] = 1'b0;
          centre_d           = low_idx;
          nbr_d              = 3'd0;
          state_d            = S_EXPAND;
        end else begin
          state_d = S_DONE;
        end
      end
      S_EXPAND: begin
        if (nbr_ok && !clicked_q[nbr_idx]) begin
          clicked_d[nbr_idx] = 1'b1;
          num_d              = num_inc;
          if (cell_val(map_flat, nbr_idx) == 4'd0) pending_d[nbr_idx] = 1'b1;
        end
        if (nbr_q == 3'd7) state_d = S_SCAN;
        else               nbr_d   = nbr_q + 3'd1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (clear) begin
      state_d   = S_IDLE;
      clicked_d = 64'd0;
      pending_d = 64'd0;
      num_d     = 6'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      clicked_q <= 64'd0;
      pending_q <= 64'd0;
      num_q     <= 6'd0;
      centre_q  <= 6'd0;
      nbr_q     <= 3'd0;
    end else begin
      state_q   <= state_d;
      clicked_q <= clicked_d;
      pending_q <= pending_d;
      num_q     <= num_d;
      centre_q  <= centre_d;
      nbr_q     <= nbr_d;
    end
  end

  assign clicked_flat = clicked_q;
  assign num_clicked  = num_q;
  assign rif.busy     = (state_q != S_IDLE);
  assign rif.done     = (state_q == S_DONE);

endmodule

// File: tb/tb_reveal_ctrl.sv
// Self-checking bench for reveal_ctrl: table of click vectors checked through
// a scoreboard queue, plus hand-written reset/clear/game_over sequences.
module tb_reveal_ctrl;

  logic         clk;
  logic         rst;
  logic [255:0] map_flat;
  logic         clear;
  logic         game_over;
  logic [63:0]  clicked_flat;
  logic [5:0]   num_clicked;

  reveal_ctrl_if rif ();

  reveal_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .map_flat     (map_flat),
    .clear        (clear),
    .game_over    (game_over),
    .rif          (rif),
    .clicked_flat (clicked_flat),
    .num_clicked  (num_clicked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] clicked;
    logic [5:0]  num;
    int          cycles;
  } exp_t;

  typedef struct {
    logic       clr;
    int         map_id;
    logic [2:0] row;
    logic [2:0] col;
    exp_t       exp;
  } vec_t;

  int           tests_run    = 0;
  int           tests_failed = 0;
  exp_t         sb[$];
  vec_t         vecs[9];
  logic [255:0] map_a, map_b, map_c;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic clr, input int m, input logic [2:0] r, input logic [2:0] c,
                              input logic [63:0] ec, input logic [5:0] en, input int cyc);
    vec_t v;
    v.clr = clr; v.map_id = m; v.row = r; v.col = c;
    v.exp.clicked = ec; v.exp.num = en; v.exp.cycles = cyc;
    return v;
  endfunction

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic start_click(input logic [2:0] r, input logic [2:0] c);
    @(negedge clk);
    rif.click_req = 1'b1; rif.click_row = r; rif.click_col = c;
    @(negedge clk);
    rif.click_req = 1'b0;
  endtask

  // Issues a click; the matching expectation must already be in the scoreboard.
  task automatic do_click(input string tag, input logic [2:0] r, input logic [2:0] c);
    int   cyc;
    bit   seen;
    exp_t e;
    start_click(r, c);
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < 2000) begin
      if (rif.done) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    e = sb.pop_front();
    if (!seen) begin
      check({tag, "_done_timeout"}, 64'(cyc), 64'(e.cycles));
    end else begin
      check({tag, "_clicked"}, clicked_flat, e.clicked);
      check({tag, "_num"},     64'(num_clicked), 64'(e.num));
      check({tag, "_latency"}, 64'(cyc), 64'(e.cycles));
      @(negedge clk);
      check({tag, "_done_once"}, 64'({rif.done, rif.busy}), 64'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   seen;
    exp_t e;

    for (int i = 0; i < 64; i++) begin
      map_a[i*4 +: 4] = 4'd1;
      map_b[i*4 +: 4] = 4'd0;
      map_c[i*4 +: 4] = ((i % 8) == 7) ? 4'd0 : 4'd1;
    end
    map_a[3:0]     = 4'd9;
    map_b[63*4 +: 4] = 4'd9;
    map_b[54*4 +: 4] = 4'd1;
    map_b[55*4 +: 4] = 4'd1;
    map_b[62*4 +: 4] = 4'd1;

    vecs[0] = mk(1, 0, 3'd3, 3'd3, 64'h0000_0000_0800_0000, 6'd1, 1);
    vecs[1] = mk(0, 0, 3'd3, 3'd3, 64'h0000_0000_0800_0000, 6'd1, 1);
    vecs[2] = mk(1, 0, 3'd0, 3'd0, 64'h0000_0000_0000_0001, 6'd1, 1);
    vecs[3] = mk(0, 0, 3'd3, 3'd3, 64'h0000_0000_0800_0001, 6'd2, 1);
    vecs[4] = mk(1, 1, 3'd0, 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 6'd63, 2 + 9*60);
    vecs[5] = mk(0, 1, 3'd7, 3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 1);
    vecs[6] = mk(1, 2, 3'd0, 3'd7, 64'hC0C0_C0C0_C0C0_C0C0, 6'd16, 2 + 9*8);
    vecs[7] = mk(0, 2, 3'd3, 3'd7, 64'hC0C0_C0C0_C0C0_C0C0, 6'd16, 1);
    vecs[8] = mk(0, 2, 3'd2, 3'd2, 64'hC0C0_C0C0_C0C4_C0C0, 6'd17, 1);

    rst = 1'b0; clear = 1'b0; game_over = 1'b0; map_flat = map_a;
    rif.click_req = 1'b0; rif.click_row = 3'd0; rif.click_col = 3'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {clicked_flat, 6'(num_clicked)} == 70'd0 ? 64'd0 : 64'd1, 64'd0);
    check("reset_handshake", 64'({rif.busy, rif.done}), 64'd0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      case (vecs[i].map_id)
        0:       map_flat = map_a;
        1:       map_flat = map_b;
        default: map_flat = map_c;
      endcase
      if (vecs[i].clr) do_clear();
      sb.push_back(vecs[i].exp);
      do_click($sformatf("vec%0d", i), vecs[i].row, vecs[i].col);
    end

    // game_over blocks requests
    @(negedge clk);
    game_over = 1'b1; rif.click_req = 1'b1; rif.click_row = 3'd5; rif.click_col = 3'd0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rif.busy || rif.done) seen = 1'b1;
    end
    rif.click_req = 1'b0; game_over = 1'b0;
    check("game_over_no_activity", 64'(seen), 64'd0);
    check("game_over_clicked", clicked_flat, 64'hC0C0_C0C0_C0C4_C0C0);
    check("game_over_num", 64'(num_clicked), 64'd17);

    // clear wins over a simultaneous request
    @(negedge clk);
    clear = 1'b1; rif.click_req = 1'b1; rif.click_row = 3'd1; rif.click_col = 3'd1;
    @(negedge clk);
    clear = 1'b0; rif.click_req = 1'b0;
    check("clear_prio_clicked", clicked_flat, 64'd0);
    check("clear_prio_num", 64'(num_clicked), 64'd0);
    @(negedge clk);
    check("clear_prio_idle", 64'({rif.busy, rif.done}), 64'd0);

    // async reset mid-flood
    map_flat = map_b;
    start_click(3'd0, 3'd0);
    repeat (19) @(negedge clk);
    check("flood_busy_before_rst", 64'(rif.busy), 64'd1);
    rst = 1'b0;
    #1;
    check("rst_mid_clicked", clicked_flat, 64'd0);
    check("rst_mid_num", 64'(num_clicked), 64'd0);
    check("rst_mid_handshake", 64'({rif.busy, rif.done}), 64'd0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rif.done) seen = 1'b1;
    end
    rst = 1'b1;
    check("rst_mid_no_done", 64'(seen), 64'd0);
    map_flat = map_a;
    e.clicked = 64'h0000_0000_0800_0000; e.num = 6'd1; e.cycles = 1;
    sb.push_back(e);
    do_click("after_rst", 3'd3, 3'd3);

    // synchronous clear mid-flood
    do_clear();
    map_flat = map_b;
    start_click(3'd0, 3'd0);
    repeat (19) @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    check("clear_mid_clicked", clicked_flat, 64'd0);
    check("clear_mid_num", 64'(num_clicked), 64'd0);
    check("clear_mid_handshake", 64'({rif.busy, rif.done}), 64'd0);
    @(negedge clk);
    clear = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rif.done || rif.busy) seen = 1'b1;
    end
    check("clear_mid_stays_idle", 64'(seen), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reveal_ctrl.md
REVEAL_CTRL -- requirements
Module: reveal_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: map_flat  in  256  cell (r,c) value at bits [(r*8+c)*4 +: 4]; 0-8 = adjacent mine count, >=9 = mine.
REQ-004 SHALL have ports: click_req  in  1  reveal request, level-sampled in IDLE.
REQ-005 SHALL have ports: click_row, click_col  in  3 each  requested cell.
REQ-006 SHALL have ports: clear  in  1  synchronous board clear for a new game.
REQ-007 SHALL have ports: game_over  in  1  dead or won; blocks new requests.
REQ-008 SHALL have ports: clicked_flat  out  64  bit r*8+c = cell revealed.
REQ-009 SHALL have ports: num_clicked  out  6  count of revealed cells.
REQ-010 SHALL have ports: busy  out  1  high in any state other than IDLE.
REQ-011 SHALL have ports: done  out  1  one-cycle pulse when a request completes.

Function
REQ-012 SHALL implement states IDLE, SCAN, EXPAND, DONE, plus a 64-bit internal pending mask.
REQ-013 IDLE accept: click_req=1, game_over=0, clear=0 -> latch cell k = row*8+col on that edge.
REQ-014 On accept with clicked[k]=1, no state SHALL change except the transition to DONE.
REQ-015 On accept with clicked[k]=0: set clicked[k] and increment num_clicked; if map(k)=0 also set pending[k] and go to SCAN, else go to DONE.
REQ-016 A mine cell (>=9) SHALL be revealed like a non-zero cell, with no flood; death detection is downstream.
REQ-017 SCAN with pending non-zero: select the lowest set index j, clear pending[j], latch j as centre, reset the 3-bit neighbour counter, go to EXPAND.
REQ-018 SCAN with pending all zero SHALL go to DONE.
REQ-019 EXPAND SHALL visit one neighbour per cycle in fixed order (-1,-1),(-1,0),(-1,+1),(0,-1),(0,+1),(+1,-1),(+1,0),(+1,+1) as (drow,dcol).
REQ-020 Out-of-bounds neighbour (row/col <0 or >7, with no wrap-around) SHALL be skipped but still consume its cycle.
REQ-021 For an in-bounds unrevealed neighbour n: set clicked[n], increment num_clicked, and set pending[n] if map(n)=0; revealed neighbours SHALL be left unchanged.
REQ-022 After the 8th neighbour, EXPAND SHALL return to SCAN.
REQ-023 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-024 Latency: non-flood request = accept edge + 1 DONE cycle.
REQ-025 Latency: flood over P zero cells = 1 + 9*P + 1 cycles before DONE.
REQ-026 num_clicked SHALL saturate at 63 and never wrap.
REQ-027 click_req SHALL be ignored outside IDLE and while game_over=1; requests are not queued.
REQ-028 clear=1 in any state SHALL zero clicked_flat, num_clicked and pending and enter IDLE next edge; no done pulse; clear has priority over click_req.
REQ-029 map_flat SHALL be held stable by its source while busy=1.

Reset
REQ-030 rst=0 SHALL asynchronously force state IDLE, clicked_flat=0, num_clicked=0, pending=0, busy=0, done=0.
REQ-031 rst=0 mid-flood SHALL abort the flood with no done pulse; operation resumes on the first clock edge after rst rises.

Verification
REQ-032 Map all 1 except (0,0)=9; click (3,3) -> clicked_flat=1<<27, num_clicked=1, done pulse on the 2nd edge after accept.
REQ-033 Map all 0 except (7,7)=9 and (6,6),(6,7),(7,6)=1; click (0,0) -> clicked_flat=all ones except bit 63, num_clicked=63, busy falls, single done pulse.
REQ-034 After REQ-032, click (3,3) again -> clicked_flat and num_clicked unchanged, done pulses once.
REQ-035 game_over=1 with click_req=1 for 10 cycles -> busy stays 0, no done, outputs unchanged.
REQ-036 Start REQ-033 flood, pulse rst=0 at cycle 20 -> all outputs 0 immediately, no done; repeat the test with clear=1 at cycle 20 -> outputs 0 on next edge, state IDLE.
REQ-037 Click mine (0,0) on REQ-032 map -> bit 0 set, num_clicked=1, no neighbours revealed.
